// File: rtl/joystick_db9_scanner.sv
// DB9 pad scanner: one SELECT sequence per frame, decoding Atari or Sega 3/6-button pads.
// JOY_SIXBUTTON_EN adds phases 2..7 for the 6-button handshake; otherwise the scan ends after p1.
module joystick_db9_scanner #(
  parameter int unsigned PHASE_CLKS = 280
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vertical_retrace_int_n,
  input  logic       joy_up,
  input  logic       joy_down,
  input  logic       joy_left,
  input  logic       joy_right,
  input  logic       joy_fire1,
  input  logic       joy_fire2,
  output logic       joy_select,
  output logic [4:0] db9joy_out,
  output logic [7:0] extra_buttons,
  output logic [1:0] pad_type,
  output logic       scan_done
);

  typedef enum logic [1:0] {S_IDLE, S_PHASE, S_UPDATE} state_t;

`ifdef JOY_SIXBUTTON_EN
  localparam logic [2:0] LAST_P = 3'd7;
`else
  localparam logic [2:0] LAST_P = 3'd1;
`endif
  localparam logic [15:0] LAST_CNT = 16'(PHASE_CLKS - 1);

  // Pin order: [5]U [4]D [3]L [2]R [1]fire1 [0]fire2
  logic [5:0]  pin_s1, pin_s2;
  logic [2:0]  vr_s;
  logic        trig;
  state_t      state;
  logic [2:0]  phase;
  logic [15:0] cnt;

  logic       sega_det, a_s, start_s, p1_f1, p1_f2;
  logic [3:0] dir_s;
  logic       six_pad;
  logic [3:0] hi_btn;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pin_s1 <= 6'h3F;
      pin_s2 <= 6'h3F;
      vr_s   <= 3'b111;
    end else begin
      pin_s1 <= {joy_up, joy_down, joy_left, joy_right, joy_fire1, joy_fire2};
      pin_s2 <= pin_s1;
      vr_s   <= {vr_s[1:0], vertical_retrace_int_n};
    end
  end

  assign trig = vr_s[2] & ~vr_s[1];

`ifdef JOY_SIXBUTTON_EN
  logic       six_det;
  logic [3:0] zyxm;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      six_det <= 1'b0;
      zyxm    <= 4'h0;
    end else if (state == S_PHASE && cnt == LAST_CNT) begin
      if (phase == 3'd4) six_det <= (pin_s2[5:2] == 4'b0000);
      if (phase == 3'd5) zyxm    <= ~pin_s2[5:2];
    end
  end

  assign six_pad = sega_det & six_det;
  assign hi_btn  = six_pad ? {zyxm[0], zyxm[1], zyxm[2], zyxm[3]} : 4'h0;
`else
  assign six_pad = 1'b0;
  assign hi_btn  = 4'h0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      phase         <= 3'd0;
      cnt           <= 16'd0;
      joy_select    <= 1'b1;
      db9joy_out    <= 5'h1F;
      extra_buttons <= 8'h00;
      pad_type      <= 2'b00;
      scan_done     <= 1'b0;
      sega_det      <= 1'b0;
      a_s           <= 1'b0;
      start_s       <= 1'b0;
      p1_f1         <= 1'b1;
      p1_f2         <= 1'b1;
      dir_s         <= 4'hF;
    end else begin
      scan_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (trig) begin
            state      <= S_PHASE;
            phase      <= 3'd0;
            cnt        <= 16'd0;
            joy_select <= 1'b0;
          end
        end
        S_PHASE: begin
          if (cnt == LAST_CNT) begin
            cnt <= 16'd0;
            case (phase)
              3'd0: begin
                sega_det <= ~pin_s2[3] & ~pin_s2[2];
                a_s      <= ~pin_s2[1];
                start_s  <= ~pin_s2[0];
              end
              3'd1: begin
                dir_s <= pin_s2[5:2];
                p1_f1 <= pin_s2[1];
                p1_f2 <= pin_s2[0];
              end
              default: ;
            endcase
            if (phase == LAST_P) begin
              state      <= S_UPDATE;
              joy_select <= 1'b1;
            end else begin
              phase      <= phase + 3'd1;
              joy_select <= ~phase[0];  // next phase odd => SELECT high
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_UPDATE: begin
          state     <= S_IDLE;
          scan_done <= 1'b1;
          if (sega_det) begin
            db9joy_out    <= {p1_f1 & p1_f2, dir_s};
            extra_buttons <= {hi_btn, start_s, a_s, ~p1_f2, ~p1_f1};
            pad_type      <= six_pad ? 2'b10 : 2'b01;
          end else begin
            db9joy_out    <= {p1_f1, dir_s};
            extra_buttons <= 8'h00;
            pad_type      <= 2'b00;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_joystick_db9_scanner.sv
// Bench for joystick_db9_scanner: pad models driven by SELECT, random pads vs a button-level model.
module tb_joystick_db9_scanner;

  localparam int P = 4;
`ifdef JOY_SIXBUTTON_EN
  localparam int NPH = 8;
  localparam bit SIX = 1'b1;
`else
  localparam int NPH = 2;
  localparam bit SIX = 1'b0;
`endif
  localparam int SCAN = NPH * P + 1;

  typedef struct packed {
    logic up, dn, lf, rt, a, b, c, st, x, y, z, md;
  } btn_t;

  logic       clk, rst_n, vr_n;
  logic       joy_up, joy_down, joy_left, joy_right, joy_fire1, joy_fire2;
  logic       joy_select, scan_done;
  logic [4:0] db9joy_out;
  logic [7:0] extra_buttons;
  logic [1:0] pad_type;

  int         pad_kind;    // 0 Atari, 1 Sega 3-btn, 2 Sega 6-btn
  logic [5:0] atari_pins;  // raw {U,D,L,R,F1,F2}
  btn_t       btn;
  int         n_low;
  int         total = 0;
  int         bad = 0;

  joystick_db9_scanner #(.PHASE_CLKS(P)) dut (
    .clk(clk), .rst_n(rst_n), .vertical_retrace_int_n(vr_n),
    .joy_up(joy_up), .joy_down(joy_down), .joy_left(joy_left), .joy_right(joy_right),
    .joy_fire1(joy_fire1), .joy_fire2(joy_fire2),
    .joy_select(joy_select), .db9joy_out(db9joy_out), .extra_buttons(extra_buttons),
    .pad_type(pad_type), .scan_done(scan_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pads count SELECT low pulses; a 6-button pad answers differently on the third one.
  always @(negedge joy_select) n_low++;

  function automatic logic [5:0] pad_pins(int kind, logic sel, int n, logic [5:0] ap, btn_t b);
    logic [5:0] r;
    if (kind == 0) r = ap;
    else if (kind == 2 && n == 3)
      r = sel ? {~b.z, ~b.y, ~b.x, ~b.md, ~b.b, ~b.c} : {4'b0000, ~b.a, ~b.st};
    else
      r = sel ? {~b.up, ~b.dn, ~b.lf, ~b.rt, ~b.b, ~b.c} : {~b.up, ~b.dn, 2'b00, ~b.a, ~b.st};
    return r;
  endfunction

  assign {joy_up, joy_down, joy_left, joy_right, joy_fire1, joy_fire2} =
    pad_pins(pad_kind, joy_select, n_low, atari_pins, btn);

  // Expected {db9joy_out, extra_buttons, pad_type} from what the player is holding.
  function automatic logic [14:0] model(int kind, logic [5:0] ap, btn_t b);
    logic [4:0] db;
    logic [7:0] ex;
    logic [1:0] pt;
    if (kind == 0) begin
      db = {ap[1], ap[5:2]};
      ex = 8'h00;
      pt = 2'b00;
    end else begin
      db = {~(b.b | b.c), ~b.up, ~b.dn, ~b.lf, ~b.rt};
      ex = {4'h0, b.st, b.a, b.c, b.b};
      pt = 2'b01;
      if (kind == 2 && SIX) begin
        ex[7:4] = {b.md, b.x, b.y, b.z};
        pt = 2'b10;
      end
    end
    return {db, ex, pt};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic do_scan(input string tag);
    int cyc, t0, td, last, ntog, bad_gap, pulses;
    logic prev;
    logic [14:0] e;
    e = model(pad_kind, atari_pins, btn);
    cyc = 0; t0 = -1; td = -1; last = -1; ntog = 0; bad_gap = 0; pulses = 0;
    prev = joy_select;
    @(negedge clk);
    n_low = 0;
    vr_n = 1'b0;
    while (cyc < SCAN + 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 4) vr_n = 1'b1;
      if (joy_select !== prev) begin
        if (t0 < 0) t0 = cyc;
        else if (cyc - last != P) bad_gap++;
        last = cyc;
        ntog++;
        prev = joy_select;
      end
      if (scan_done === 1'b1) begin
        pulses++;
        if (td < 0) td = cyc;
      end
    end
    check({tag, ".toggles"}, ntog, NPH);
    check({tag, ".sel_gap"}, bad_gap, 0);
    check({tag, ".latency"}, (t0 < 0 || td < 0) ? -1 : td - t0, SCAN);
    check({tag, ".pulses"}, pulses, 1);
    check({tag, ".db9"}, db9joy_out, e[14:10]);
    check({tag, ".extra"}, extra_buttons, e[9:2]);
    check({tag, ".type"}, pad_type, e[1:0]);
  endtask

  initial begin
    int cyc, t0, pulses, falls;
    logic prev;
    rst_n = 1'b0;
    vr_n = 1'b1;
    pad_kind = 0;
    atari_pins = 6'h3F;
    btn = '0;
    n_low = 0;

    repeat (3) @(negedge clk);
    check("rst.sel", joy_select, 1'b1);
    check("rst.db9", db9joy_out, 5'h1F);
    check("rst.extra", extra_buttons, 8'h00);
    check("rst.type", pad_type, 2'b00);
    check("rst.done", scan_done, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst.sel", joy_select, 1'b1);
    check("post_rst.db9", db9joy_out, 5'h1F);

    // Atari stick, up and fire held
    pad_kind = 0; atari_pins = 6'b011101;
    do_scan("atari");
    check("atari.db9_lit", db9joy_out, 5'b00111);

    // Sega 3-button, A and Right held
    pad_kind = 1; btn = '0; btn.a = 1'b1; btn.rt = 1'b1;
    do_scan("sega3");
    check("sega3.db9_lit", db9joy_out, 5'b11110);
    check("sega3.extra_lit", extra_buttons, 8'h04);

    // Sega 6-button, X and Start held
    pad_kind = 2; btn = '0; btn.x = 1'b1; btn.st = 1'b1;
    do_scan("sega6");
    check("sega6.type_lit", pad_type, SIX ? 2'b10 : 2'b01);

    for (int i = 0; i < 16; i++) begin
      pad_kind = int'($urandom_range(0, 2));
      atari_pins = 6'($urandom);
      if (atari_pins[3:2] == 2'b00) atari_pins[2] = 1'b1;
      btn = btn_t'($urandom);
      if (btn.up && btn.dn) btn.dn = 1'b0;
      if (btn.lf && btn.rt) btn.rt = 1'b0;
      do_scan($sformatf("rnd%0d", i));
    end

    // A retrigger inside a scan must be ignored, not queued
    pad_kind = 1; btn = '0; btn.c = 1'b1; btn.up = 1'b1;
    cyc = 0; t0 = -1; pulses = 0; falls = 0;
    @(negedge clk);
    prev = joy_select;
    n_low = 0;
    vr_n = 1'b0;
    while (cyc < 3 * SCAN + 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 4) vr_n = 1'b1;
      if (t0 < 0 && joy_select === 1'b0) t0 = cyc;
      if (t0 > 0 && cyc == t0 + P + 1) vr_n = 1'b0;
      if (t0 > 0 && cyc == t0 + P + 4) vr_n = 1'b1;
      if (prev === 1'b1 && joy_select === 1'b0) falls++;
      prev = joy_select;
      if (scan_done === 1'b1) pulses++;
    end
    check("retrig.pulses", pulses, 1);
    check("retrig.sel_falls", falls, NPH / 2);
    check("retrig.db9", db9joy_out, 5'b00111);
    check("retrig.extra", extra_buttons, 8'h02);

    // Reset in the last phase aborts the scan
    cyc = 0; t0 = -1; pulses = 0;
    @(negedge clk);
    n_low = 0;
    vr_n = 1'b0;
    while (cyc < SCAN + 20 && rst_n) begin
      @(negedge clk);
      cyc++;
      if (cyc == 4) vr_n = 1'b1;
      if (t0 < 0 && joy_select === 1'b0) t0 = cyc;
      if (t0 > 0 && cyc == t0 + (NPH - 1) * P + 1) rst_n = 1'b0;
    end
    check("abort.reached", rst_n, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort.sel", joy_select, 1'b1);
    check("abort.db9", db9joy_out, 5'h1F);
    check("abort.extra", extra_buttons, 8'h00);
    check("abort.type", pad_type, 2'b00);
    falls = 0;
    for (int k = 0; k < SCAN + 10; k++) begin
      @(negedge clk);
      if (scan_done === 1'b1) pulses++;
      if (joy_select !== 1'b1) falls++;
    end
    check("abort.no_scan", pulses, 0);
    check("abort.sel_idle", falls, 0);

    pad_kind = 0; atari_pins = 6'b110110;
    do_scan("after_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
